mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer for the single-port unified instruction/data memory shared by the Fetch (IF) and Memory (MEM) stages of the 5-stage RISC-V pipeline. It accepts one request from each stage and grants the memory to one at a time. It holds the granted access for a fixed number of wait states and returns a one-cycle ready strobe plus read data. It also produces per-stage stall signals consumed by the hazard unit.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYCLES, 2, memory wait states (≥0); each access occupies WAIT_CYCLES+1 busy cycles
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- IReq  in  1  fetch request, held high until IReady seen
- IAddr  in  ADDR_W  fetch address
- IRdata  out  DATA_W  fetched word, valid only while IReady=1
- IReady  out  1  fetch completion strobe
- DReq  in  1  data request, held high until DReady seen
- DWe  in  1  1 = store, 0 = load
- DAddr  in  ADDR_W  data address
- DWdata  in  DATA_W  store data
- DRdata  out  DATA_W  load data, valid only while DReady=1
- DReady  out  1  data completion strobe (loads and stores)
- StallF  out  1  IReq & ~IReady
- StallM  out  1  DReq & ~DReady
- MemEn  out  1  memory access enable
- MemWe  out  1  memory write enable
- MemAddr  out  ADDR_W  memory address
- MemWdata  out  DATA_W  memory write data
- MemRdata  in  DATA_W  memory read data, valid in final busy cycle

## Operation
- States: IDLE, BUSY_I, BUSY_D. Reset → IDLE.
- IDLE, neither request: stay. Only DReq: go to BUSY_D. Only IReq: go to BUSY_I.
- IDLE, both requests: alternate priority via last_grant flag. Grant I if last_grant=D, else grant D. After reset last_grant=I, so D wins the first conflict.
- On grant edge: latch address, DWe (forced 0 for I), DWdata into request registers. Clear cnt to 0. Update last_grant.
- BUSY_x: MemEn=1. MemWe, MemAddr, MemWdata come from the latched registers and are stable for the whole access. cnt increments each cycle.
- Final busy cycle (cnt==WAIT_CYCLES): xReady=1 combinationally. xRdata=MemRdata. Next state is IDLE.
- IRdata/DRdata pass MemRdata through unconditionally. They are meaningful only with the matching Ready.
- IDLE: MemEn=0, MemWe=0. MemAddr/MemWdata hold their last latched values.
- cnt width: max(1, $clog2(WAIT_CYCLES+1)). cnt never exceeds WAIT_CYCLES.
- Request dropped mid-access: the access still completes and Ready still pulses. There is no abort. Latched inputs are unaffected by input changes after the grant.
- Requester keeps IReq/DReq high until it sees Ready, then advances on that edge. It may re-request from the next cycle.

## Timing
- Reset (async, while reset=0) forces:
  - state=IDLE, cnt=0, last_grant=I
  - MemEn=0, MemWe=0, MemAddr=0, MemWdata=0
  - IReady=0, DReady=0
- StallF/StallM are combinational and equal IReq/DReq during reset.
- Latency: a request high in IDLE cycle t gives MemEn=1 in cycles t+1 … t+1+WAIT_CYCLES. Ready is asserted in cycle t+1+WAIT_CYCLES.
- Throughput: one IDLE cycle between consecutive accesses, so WAIT_CYCLES+2 cycles per access.
- WAIT_CYCLES=0: a single busy cycle with Ready in that same cycle.
- Reset asserted mid-access: the access is discarded with no Ready pulse. After release, arbitration restarts from IDLE with D priority.
- Ready is never asserted in IDLE. IReady and DReady are never high together.

## Test plan
- Single fetch, WAIT_CYCLES=2: IReq=1, IAddr=0x100 at cycle 0, MemRdata=0x00500093 → MemEn=1, MemAddr=0x100 in cycles 1–3; IReady=1, IRdata=0x00500093 in cycle 3 only; StallF=1 in cycles 0–2.
- Store: DReq=1, DWe=1, DAddr=0x200, DWdata=0xDEADBEEF → MemWe=1, MemWdata=0xDEADBEEF for 3 cycles; DReady pulses in cycle 3; MemWe=0 in cycle 4.
- Conflict after reset: IReq=DReq=1 held continuously → grant order D, I, D, I. Each Ready is 4 cycles apart. No back-to-back grant to the same port while the other is waiting.
- Input change mid-access: DAddr changes 0x200→0x300 in cycle 2 of a busy access → MemAddr stays 0x200 until completion.
- Reset in cycle 2 of BUSY_I → MemEn=0 immediately and no IReady. After release with both requests pending, D is granted first.
- WAIT_CYCLES=0 build: IReq high continuously → MemEn alternates 1,0,1,0. IReady pulses every 2 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the single-port unified memory shared by the fetch and
// memory pipeline stages: one access at a time, fixed wait states, Ready strobes.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [DATA_W-1:0] IRdata,
  output logic              IReady,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWdata,
  output logic [DATA_W-1:0] DRdata,
  output logic              DReady,
  output logic              StallF,
  output logic              StallM,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  // last_grant: 0 = fetch port, 1 = data port
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_i, grant_d;
  logic              last_cycle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Request registers are captured only on a grant edge, so requester inputs
  // may change freely while an access is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant_i) begin
      addr_q  <= IAddr;
      we_q    <= 1'b0;
      wdata_q <= DWdata;
    end else if (grant_d) begin
      addr_q  <= DAddr;
      we_q    <= DWe;
      wdata_q <= DWdata;
    end
  end

  assign last_cycle = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (IReq && DReq) begin
          grant_i = last_grant_q;
          grant_d = !last_grant_q;
        end else begin
          grant_i = IReq;
          grant_d = DReq;
        end
        cnt_d = '0;
        if (grant_i) begin
          state_d      = BUSY_I;
          last_grant_d = 1'b0;
        end else if (grant_d) begin
          state_d      = BUSY_D;
          last_grant_d = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (last_cycle) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    MemEn       = (state_q != IDLE);
    MemWe       = (state_q == BUSY_D) && we_q;
    MemAddr     = addr_q;
    MemWdata    = wdata_q;
    IReady      = (state_q == BUSY_I) && last_cycle;
    DReady      = (state_q == BUSY_D) && last_cycle;
    IRdata      = MemRdata;
    DRdata      = MemRdata;
    StallF      = IReq && !IReady;
    StallM      = DReq && !DReady;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a WAIT_CYCLES=2 instance for the main scenarios
// and a WAIT_CYCLES=0 instance for the single-busy-cycle build.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        IReq, DReq, DWe;
  logic [31:0] IAddr, DAddr, DWdata, MemRdata;
  logic [31:0] IRdata, DRdata, MemAddr, MemWdata;
  logic        IReady, DReady, StallF, StallM, MemEn, MemWe;
  logic [1:0]  dbg_state;

  logic        i0_req;
  logic [31:0] i0_addr;
  logic        zero_bit;
  logic [31:0] zero_word;
  logic [31:0] irdata0, drdata0, mem_addr0, mem_wdata0;
  logic        iready0, dready0, stallf0, stallm0, mem_en0, mem_we0;
  logic [1:0]  dbg_state0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IReady(IReady),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
    .DRdata(DRdata), .DReady(DReady),
    .StallF(StallF), .StallM(StallM),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .dbg_state_o(dbg_state)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .IReq(i0_req), .IAddr(i0_addr), .IRdata(irdata0), .IReady(iready0),
    .DReq(zero_bit), .DWe(zero_bit), .DAddr(zero_word), .DWdata(zero_word),
    .DRdata(drdata0), .DReady(dready0),
    .StallF(stallf0), .StallM(stallm0),
    .MemEn(mem_en0), .MemWe(mem_we0), .MemAddr(mem_addr0), .MemWdata(mem_wdata0),
    .MemRdata(MemRdata), .dbg_state_o(dbg_state0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; IReq = 1'b0; DReq = 1'b0; DWe = 1'b0;
    IAddr = '0; DAddr = '0; DWdata = '0; MemRdata = '0;
    i0_req = 1'b0; i0_addr = '0; zero_bit = 1'b0; zero_word = '0;

    // Reset values; stalls follow requests even in reset
    repeat (2) @(negedge clk);
    IReq = 1'b1; DReq = 1'b1;
    #1;
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_mem_en", 64'(MemEn), 64'd0);
    chk("rst_mem_we", 64'(MemWe), 64'd0);
    chk("rst_mem_addr", 64'(MemAddr), 64'd0);
    chk("rst_mem_wdata", 64'(MemWdata), 64'd0);
    chk("rst_iready", 64'(IReady), 64'd0);
    chk("rst_dready", 64'(DReady), 64'd0);
    chk("rst_stallf", 64'(StallF), 64'd1);
    chk("rst_stallm", 64'(StallM), 64'd1);
    chk("rst_mem_en0", 64'(mem_en0), 64'd0);
    tick;
    IReq = 1'b0; DReq = 1'b0;
    tick;
    reset = 1'b1;

    // Single fetch
    tick;
    IReq = 1'b1; IAddr = 32'h100; MemRdata = 32'h0050_0093;
    @(negedge clk);
    chk("f0_stallf", 64'(StallF), 64'd1);
    chk("f0_mem_en", 64'(MemEn), 64'd0);
    for (int c = 1; c <= 3; c++) begin
      tick;
      @(negedge clk);
      chk("f_mem_en", 64'(MemEn), 64'd1);
      chk("f_mem_addr", 64'(MemAddr), 64'h100);
      chk("f_mem_we", 64'(MemWe), 64'd0);
      chk("f_iready", 64'(IReady), 64'(c == 3));
      chk("f_dready", 64'(DReady), 64'd0);
      chk("f_stallf", 64'(StallF), 64'(c != 3));
      if (c == 3) chk("f_irdata", 64'(IRdata), 64'h0050_0093);
    end
    tick;
    IReq = 1'b0;
    @(negedge clk);
    chk("f4_mem_en", 64'(MemEn), 64'd0);
    chk("f4_iready", 64'(IReady), 64'd0);
    chk("f4_state", 64'(dbg_state), 64'd0);

    // Store, with the address changing mid-access
    tick;
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h200; DWdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("s0_stallm", 64'(StallM), 64'd1);
    for (int c = 1; c <= 3; c++) begin
      tick;
      if (c == 2) begin
        DAddr = 32'h300; DWdata = 32'h1234_5678;
      end
      @(negedge clk);
      chk("s_state", 64'(dbg_state), 64'd2);
      chk("s_mem_en", 64'(MemEn), 64'd1);
      chk("s_mem_we", 64'(MemWe), 64'd1);
      chk("s_mem_addr", 64'(MemAddr), 64'h200);
      chk("s_mem_wdata", 64'(MemWdata), 64'hDEAD_BEEF);
      chk("s_dready", 64'(DReady), 64'(c == 3));
      chk("s_stallm", 64'(StallM), 64'(c != 3));
      chk("s_iready", 64'(IReady), 64'd0);
    end
    tick;
    DReq = 1'b0; DWe = 1'b0;
    @(negedge clk);
    chk("s4_mem_we", 64'(MemWe), 64'd0);
    chk("s4_mem_en", 64'(MemEn), 64'd0);
    chk("s4_dready", 64'(DReady), 64'd0);

    // Conflict after a fresh reset: grants D, I, D, I
    tick; reset = 1'b0;
    tick; reset = 1'b1;
    tick;
    IReq = 1'b1; DReq = 1'b1; IAddr = 32'h400; DAddr = 32'h500;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) tick;
      @(negedge clk);
      chk("c_mem_en", 64'(MemEn), 64'((c % 4) != 0));
      chk("c_dready", 64'(DReady), 64'(c == 3 || c == 11));
      chk("c_iready", 64'(IReady), 64'(c == 7 || c == 15));
      if ((c % 4) != 0)
        chk("c_mem_addr", 64'(MemAddr), (((c / 4) % 2) == 0) ? 64'h500 : 64'h400);
    end
    tick;
    IReq = 1'b0; DReq = 1'b0;
    @(negedge clk);
    chk("c16_mem_en", 64'(MemEn), 64'd0);

    // Reset in the second busy cycle of a fetch
    tick;
    IReq = 1'b1; IAddr = 32'h600;
    tick;
    @(negedge clk);
    chk("r1_state", 64'(dbg_state), 64'd1);
    tick;
    reset = 1'b0; DReq = 1'b1; DAddr = 32'h700;
    #1;
    chk("r2_mem_en", 64'(MemEn), 64'd0);
    chk("r2_iready", 64'(IReady), 64'd0);
    chk("r2_state", 64'(dbg_state), 64'd0);
    chk("r2_mem_addr", 64'(MemAddr), 64'd0);
    tick;
    reset = 1'b1;
    @(negedge clk);
    chk("r3_state", 64'(dbg_state), 64'd0);
    chk("r3_iready", 64'(IReady), 64'd0);
    for (int c = 1; c <= 3; c++) begin
      tick;
      @(negedge clk);
      chk("rd_state", 64'(dbg_state), 64'd2);
      chk("rd_mem_addr", 64'(MemAddr), 64'h700);
      chk("rd_dready", 64'(DReady), 64'(c == 3));
      chk("rd_iready", 64'(IReady), 64'd0);
    end
    tick;
    IReq = 1'b0; DReq = 1'b0;

    // Zero-wait-state build: continuous fetch alternates busy/idle
    tick;
    i0_req = 1'b1; i0_addr = 32'h800; MemRdata = 32'hCAFE_0001;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick;
      @(negedge clk);
      chk("w0_mem_en", 64'(mem_en0), 64'(c % 2));
      chk("w0_iready", 64'(iready0), 64'(c % 2));
      chk("w0_stallf", 64'(stallf0), 64'((c % 2) == 0));
      if ((c % 2) == 1) begin
        chk("w0_mem_addr", 64'(mem_addr0), 64'h800);
        chk("w0_irdata", 64'(irdata0), 64'hCAFE_0001);
      end
    end
    tick;
    i0_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
